// File: rtl/knn_sort_sched.sv
// Batch scheduler for the 8-in/top-4-out sorter: packs candidates into 8-wide batches
// and recirculates the running best-4 until the query's last candidate, then presents the result.
module knn_sort_sched #(
  parameter int unsigned DATA_W = 11,
  parameter int unsigned IDX_W  = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cand_valid,
  output logic                cand_ready,
  input  logic [DATA_W-1:0]   cand_dist,
  input  logic [IDX_W-1:0]    cand_idx,
  input  logic                cand_last,
  output logic                srt_valid_in,
  output logic [8*DATA_W-1:0] srt_data_in,
  output logic [8*IDX_W-1:0]  srt_idx_in,
  input  logic                srt_valid_out,
  input  logic [4*DATA_W-1:0] srt_data_out,
  input  logic [4*IDX_W-1:0]  srt_idx_out,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [4*DATA_W-1:0] res_dist,
  output logic [4*IDX_W-1:0]  res_idx,
  output logic [2:0]          res_cnt
);
  localparam int unsigned NSLOT = 8;
  localparam int unsigned NKEEP = 4;
  localparam logic [DATA_W-1:0] PAD_D = '1;
  localparam logic [IDX_W-1:0]  PAD_I = '1;

  typedef enum logic [1:0] {S_FILL, S_ISSUE, S_WAIT, S_OUT} state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   dist_q [NSLOT];
  logic [IDX_W-1:0]    idx_q  [NSLOT];
  logic [3:0]          ptr_q;
  logic                last_q;
  logic [2:0]          cnt_q;
  logic                ready_q;
  logic                srt_vld_q;
  logic                res_vld_q;
  logic [4*DATA_W-1:0] res_dist_q;
  logic [4*IDX_W-1:0]  res_idx_q;
  logic [2:0]          res_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FILL;
      ptr_q      <= '0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      srt_vld_q  <= 1'b0;
      res_vld_q  <= 1'b0;
      res_dist_q <= '0;
      res_idx_q  <= '0;
      res_cnt_q  <= '0;
      for (int unsigned s = 0; s < NSLOT; s++) begin
        dist_q[s] <= PAD_D;
        idx_q[s]  <= PAD_I;
      end
    end else begin
      srt_vld_q <= 1'b0;
      case (state_q)
        S_FILL: begin
          ready_q <= 1'b1;
          if (cand_valid && ready_q) begin
            dist_q[ptr_q[2:0]] <= cand_dist;
            idx_q[ptr_q[2:0]]  <= cand_idx;
            ptr_q              <= ptr_q + 4'd1;
            if (cnt_q != 3'(NKEEP)) cnt_q <= cnt_q + 3'd1;
            if (cand_last) last_q <= 1'b1;
            // Batch closes on the query's last candidate or when all 8 slots are used
            if (cand_last || ptr_q == 4'(NSLOT - 1)) begin
              state_q   <= S_ISSUE;
              ready_q   <= 1'b0;
              srt_vld_q <= 1'b1;
            end
          end
        end
        S_ISSUE: state_q <= S_WAIT;
        S_WAIT: begin
          if (srt_valid_out) begin
            for (int unsigned s = 0; s < NKEEP; s++) begin
              dist_q[s] <= srt_data_out[s*DATA_W +: DATA_W];
              idx_q[s]  <= srt_idx_out[s*IDX_W +: IDX_W];
            end
            for (int unsigned s = NKEEP; s < NSLOT; s++) begin
              dist_q[s] <= PAD_D;
              idx_q[s]  <= PAD_I;
            end
            if (last_q) begin
              state_q    <= S_OUT;
              res_vld_q  <= 1'b1;
              res_dist_q <= srt_data_out;
              res_idx_q  <= srt_idx_out;
              res_cnt_q  <= cnt_q;
            end else begin
              state_q <= S_FILL;
              ptr_q   <= 4'(NKEEP);
              ready_q <= 1'b1;
            end
          end
        end
        S_OUT: begin
          if (res_ready) begin
            state_q   <= S_FILL;
            res_vld_q <= 1'b0;
            ready_q   <= 1'b1;
            ptr_q     <= '0;
            last_q    <= 1'b0;
            cnt_q     <= '0;
            for (int unsigned s = 0; s < NSLOT; s++) begin
              dist_q[s] <= PAD_D;
              idx_q[s]  <= PAD_I;
            end
          end
        end
        default: state_q <= S_FILL;
      endcase
    end
  end

  // Sorter inputs come straight from the slot registers
  always_comb begin
    for (int unsigned s = 0; s < NSLOT; s++) begin
      srt_data_in[s*DATA_W +: DATA_W] = dist_q[s];
      srt_idx_in[s*IDX_W +: IDX_W]    = idx_q[s];
    end
  end

  assign cand_ready   = ready_q;
  assign srt_valid_in = srt_vld_q;
  assign res_valid    = res_vld_q;
  assign res_dist     = res_dist_q;
  assign res_idx      = res_idx_q;
  assign res_cnt      = res_cnt_q;

endmodule

// File: tb/tb_knn_sort_sched.sv
// Bench for knn_sort_sched: behavioural sorter with fixed latency plus a sort-all reference
// for each query's top-4, directed and random queries, reset and handshake corner cases.
module tb_knn_sort_sched;
  localparam int DW = 11;
  localparam int IW = 9;
  localparam int L  = 6;
  localparam logic [DW-1:0] PD = '1;
  localparam logic [IW-1:0] PI = '1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cand_valid = 1'b0;
  logic          cand_ready;
  logic [DW-1:0] cand_dist = '0;
  logic [IW-1:0] cand_idx = '0;
  logic          cand_last = 1'b0;
  logic          srt_valid_in;
  logic [8*DW-1:0] srt_data_in;
  logic [8*IW-1:0] srt_idx_in;
  logic          srt_valid_out;
  logic [4*DW-1:0] srt_data_out;
  logic [4*IW-1:0] srt_idx_out;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [4*DW-1:0] res_dist;
  logic [4*IW-1:0] res_idx;
  logic [2:0]    res_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  knn_sort_sched #(.DATA_W(DW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst),
    .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_dist(cand_dist),
    .cand_idx(cand_idx), .cand_last(cand_last),
    .srt_valid_in(srt_valid_in), .srt_data_in(srt_data_in), .srt_idx_in(srt_idx_in),
    .srt_valid_out(srt_valid_out), .srt_data_out(srt_data_out), .srt_idx_out(srt_idx_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_dist(res_dist),
    .res_idx(res_idx), .res_cnt(res_cnt)
  );

  // Behavioural sorter: stable ascending sort of 8 pairs, top-4 returned L cycles later
  logic            mbusy = 1'b0;
  int              mcd = 0;
  logic            model_vo = 1'b0;
  logic            stray_vo = 1'b0;
  logic [4*DW-1:0] model_d = '0;
  logic [4*IW-1:0] model_i = '0;
  int              nb = 0;
  int              overlap = 0;
  logic [8*DW-1:0] bd_q[$];
  logic [8*IW-1:0] bi_q[$];
  logic [4*DW-1:0] rd_q[$];
  logic [4*IW-1:0] ri_q[$];

  assign srt_valid_out = model_vo | stray_vo;
  assign srt_data_out  = model_d;
  assign srt_idx_out   = model_i;

  function automatic void sort_top4(input logic [8*DW-1:0] d, input logic [8*IW-1:0] ix,
                                    output logic [4*DW-1:0] od, output logic [4*IW-1:0] oi);
    logic [DW-1:0] a [8];
    logic [IW-1:0] b [8];
    logic [DW-1:0] ta;
    logic [IW-1:0] tbv;
    for (int s = 0; s < 8; s++) begin
      a[s] = d[s*DW +: DW];
      b[s] = ix[s*IW +: IW];
    end
    for (int p = 0; p < 8; p++)
      for (int j = 0; j < 7; j++)
        if (a[j] > a[j+1]) begin
          ta = a[j]; a[j] = a[j+1]; a[j+1] = ta;
          tbv = b[j]; b[j] = b[j+1]; b[j+1] = tbv;
        end
    for (int s = 0; s < 4; s++) begin
      od[s*DW +: DW] = a[s];
      oi[s*IW +: IW] = b[s];
    end
  endfunction

  always @(posedge clk) begin : sorter_model
    logic [4*DW-1:0] td;
    logic [4*IW-1:0] ti;
    model_vo <= 1'b0;
    if (mbusy) begin
      if (mcd == 1) begin
        model_vo <= 1'b1;
        mbusy    <= 1'b0;
      end
      mcd <= mcd - 1;
    end
    if (srt_valid_in) begin
      if (mbusy) overlap <= overlap + 1;
      sort_top4(srt_data_in, srt_idx_in, td, ti);
      model_d <= td;
      model_i <= ti;
      bd_q.push_back(srt_data_in);
      bi_q.push_back(srt_idx_in);
      rd_q.push_back(td);
      ri_q.push_back(ti);
      nb    <= nb + 1;
      mbusy <= 1'b1;
      mcd   <= L;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [IW-1:0] ix, input logic last);
    int n = 0;
    @(negedge clk);
    cand_valid = 1'b1; cand_dist = d; cand_idx = ix; cand_last = last;
    while (!cand_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", 128'(n < 200), 128'(1));
    @(posedge clk);
    #1 cand_valid = 1'b0; cand_last = 1'b0;
  endtask

  task automatic wait_res(input logic [4*DW-1:0] ed, input logic [4*IW-1:0] ei,
                          input logic [2:0] ec, input int hold);
    int n = 0;
    while (!res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("res_timeout", 128'(n < 200), 128'(1));
    chk("res_dist", 128'(res_dist), 128'(ed));
    chk("res_idx", 128'(res_idx), 128'(ei));
    chk("res_cnt", 128'(res_cnt), 128'(ec));
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", 128'(res_valid), 128'(1));
      chk("hold_dist", 128'(res_dist), 128'(ed));
      chk("hold_ready", 128'(cand_ready), 128'(0));
      chk("hold_srt", 128'(srt_valid_in), 128'(0));
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    chk("hs_ready", 128'(cand_ready), 128'(1));
    chk("hs_valid", 128'(res_valid), 128'(0));
  endtask

  // Random query with unique non-pad distances, checked against a sort of all candidates
  task automatic run_rand(input int n, input int hold);
    logic [DW-1:0] d[$];
    logic [IW-1:0] ix[$];
    int keys[$];
    int nb0, b0, nbexp, first, pos;
    logic [4*DW-1:0] ed, xd;
    logic [4*IW-1:0] ei, xi;
    logic [DW-1:0] v;
    bit dup;
    while (d.size() < n) begin
      v = DW'($urandom_range(0, 2046));
      dup = 1'b0;
      foreach (d[k]) if (d[k] == v) dup = 1'b1;
      if (!dup) begin
        d.push_back(v);
        ix.push_back(IW'($urandom_range(0, 510)));
      end
    end
    nb0 = nb;
    b0  = bd_q.size();
    for (int k = 0; k < n; k++) send(d[k], ix[k], k == n - 1);
    foreach (d[k]) keys.push_back((int'(d[k]) << IW) | int'(ix[k]));
    while (keys.size() < 4) keys.push_back((int'(PD) << IW) | int'(PI));
    keys.sort();
    for (int s = 0; s < 4; s++) begin
      ed[s*DW +: DW] = DW'(keys[s] >> IW);
      ei[s*IW +: IW] = IW'(keys[s]);
    end
    wait_res(ed, ei, 3'((n < 4) ? n : 4), hold);
    nbexp = (n <= 8) ? 1 : 1 + (n - 8 + 3) / 4;
    chk("batch_count", 128'(nb - nb0), 128'(nbexp));
    for (int k = 1; k < nbexp; k++) begin
      if (b0 + k < bd_q.size()) begin
        first = 8 + 4 * (k - 1);
        for (int s = 0; s < 4; s++) begin
          pos = first + s;
          xd[s*DW +: DW] = (pos < n) ? d[pos] : PD;
          xi[s*IW +: IW] = (pos < n) ? ix[pos] : PI;
        end
        chk("recirc_dist", 128'(bd_q[b0+k][4*DW-1:0]), 128'(rd_q[b0+k-1]));
        chk("recirc_idx", 128'(bi_q[b0+k][4*IW-1:0]), 128'(ri_q[b0+k-1]));
        chk("new_dist", 128'(bd_q[b0+k][8*DW-1:4*DW]), 128'(xd));
        chk("new_idx", 128'(bi_q[b0+k][8*IW-1:4*IW]), 128'(xi));
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 128'(cand_ready), 128'(0));
    chk({tag, "_srtv"}, 128'(srt_valid_in), 128'(0));
    chk({tag, "_srtd"}, 128'(srt_data_in), 128'({8*DW{1'b1}}));
    chk({tag, "_srti"}, 128'(srt_idx_in), 128'({8*IW{1'b1}}));
    chk({tag, "_resv"}, 128'(res_valid), 128'(0));
    chk({tag, "_resd"}, 128'(res_dist), 128'(0));
    chk({tag, "_resi"}, 128'(res_idx), 128'(0));
    chk({tag, "_resc"}, 128'(res_cnt), 128'(0));
  endtask

  initial begin : stim
    int nb0, b0, n;
    logic [8*DW-1:0] e1;
    // Reset values
    repeat (2) @(negedge clk);
    chk_reset_vals("rst0");
    rst = 1'b0;
    @(posedge clk);
    #1 chk("ready_after_rst", 128'(cand_ready), 128'(1));

    // Three-candidate query, single padded batch
    nb0 = nb; b0 = bd_q.size();
    send(11'd5, 9'd1, 1'b0);
    send(11'd2, 9'd2, 1'b0);
    send(11'd9, 9'd3, 1'b1);
    wait_res({11'h7FF, 11'd9, 11'd5, 11'd2}, {9'h1FF, 9'd3, 9'd1, 9'd2}, 3'd3, 0);
    chk("q3_batches", 128'(nb - nb0), 128'(1));
    e1 = '1;
    e1[0 +: DW] = 11'd5; e1[DW +: DW] = 11'd2; e1[2*DW +: DW] = 11'd9;
    chk("q3_batch_data", 128'(bd_q[b0]), 128'(e1));

    // Eight descending candidates, exactly one full batch
    nb0 = nb;
    for (int k = 0; k < 8; k++) send(DW'(80 - 10 * k), IW'(k), k == 7);
    wait_res({11'd40, 11'd30, 11'd20, 11'd10}, {9'd4, 9'd5, 9'd6, 9'd7}, 3'd4, 0);
    chk("q8_batches", 128'(nb - nb0), 128'(1));

    // Stray sorter pulse while filling must be ignored
    @(negedge clk); stray_vo = 1'b1;
    @(negedge clk); stray_vo = 1'b0;
    chk("stray_resv", 128'(res_valid), 128'(0));
    chk("stray_slots", 128'(srt_data_in), 128'({8*DW{1'b1}}));
    chk("stray_ready", 128'(cand_ready), 128'(1));

    run_rand(12, 0);
    run_rand(9, 10);
    run_rand(13, 0);
    run_rand(20, 0);
    run_rand(1, 0);
    run_rand(4, 0);

    // Real all-ones distance still counts toward res_cnt
    send(11'h7FF, 9'd5, 1'b0);
    send(11'd3, 9'd6, 1'b1);
    wait_res({11'h7FF, 11'h7FF, 11'h7FF, 11'd3}, {9'h1FF, 9'h1FF, 9'd5, 9'd6}, 3'd2, 0);

    // Reset while a batch is outstanding; the late sorter result must be dropped
    for (int k = 0; k < 8; k++) send(DW'(100 + k), IW'(k), k == 7);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1 chk_reset_vals("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while ((mbusy || model_vo) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("late_res_timeout", 128'(n < 50), 128'(1));
    @(negedge clk);
    chk("late_resv", 128'(res_valid), 128'(0));
    chk("late_slots", 128'(srt_data_in), 128'({8*DW{1'b1}}));
    chk("late_ready", 128'(cand_ready), 128'(1));
    chk("late_srtv", 128'(srt_valid_in), 128'(0));
    run_rand(3, 0);

    chk("no_overlap", 128'(overlap), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
